// File: rtl/vga_pkg.sv
// Shared timing defaults, pipeline control word and pixel-format helpers
// for the VGA display engine.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Raster counter width; covers totals up to 4095.
    localparam int unsigned CNT_W = 12;

    typedef enum logic {
        PIX_RGB332 = 1'b0,
        PIX_GREY   = 1'b1
    } pix_mode_e;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       in_win;
        logic       fstart;
        logic [9:0] x;
        logic [9:0] y;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0,
                                    in_win: 1'b0, fstart: 1'b0, x: '0, y: '0};

    function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with raw (unpipelined) sync/active flags and line/frame-end strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             active,
    output logic             line_end,
    output logic             frame_end
);

    localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= frame_end ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_comb begin
        line_end  = (hcnt == H_LAST);
        frame_end = line_end && (vcnt == V_LAST);
        hsync_raw = !((hcnt >= HS_LO) && (hcnt <= HS_HI));
        vsync_raw = !((vcnt >= VS_LO) && (vcnt <= VS_HI));
        active    = (hcnt < H_ACT) && (vcnt < V_ACT);
    end

endmodule

// File: rtl/vga_display_engine.sv
// VGA display engine: timing, scaled frame-buffer address generation, RAM-latency
// aligned control pipeline and colour decode, all on the pixel clock.
module vga_display_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned FB_W     = 160,
    parameter int unsigned FB_H     = 120,
    parameter int unsigned SCALE    = 4,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned RAM_LAT  = 1,
    parameter logic [23:0] BORDER   = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic              hsync,
    output logic              vsync,
    output logic              sync_b,
    output logic              blank_b,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              frame_start,
    output logic [9:0]        x,
    output logic [9:0]        y
);

    localparam int unsigned DL    = RAM_LAT + 1;
    localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [CNT_W-1:0]  WIN_W    = CNT_W'(FB_W * SCALE);
    localparam logic [CNT_W-1:0]  WIN_H    = CNT_W'(FB_H * SCALE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

    logic [CNT_W-1:0]  hcnt, vcnt;
    logic              hsync_raw, vsync_raw, active, line_end, frame_end;
    logic              in_win;
    logic [ADDR_W-1:0] col, row_base;
    logic [SUB_W-1:0]  hsub, vsub;
    pix_mode_e         mode_q;
    ctrl_t             ctrl0;
    ctrl_t             pipe [DL];
    ctrl_t             last;
    logic [23:0]       pix;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .active    (active),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    assign in_win = active && (hcnt < WIN_W) && (vcnt < WIN_H);

    // col/row_base always describe the stage-0 pixel, so the address is a plain add.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            hsub     <= '0;
            row_base <= '0;
            vsub     <= '0;
        end else begin
            if (line_end) begin
                col  <= '0;
                hsub <= '0;
            end else if (in_win) begin
                if (hsub == SUB_LAST) begin
                    hsub <= '0;
                    col  <= col + 1'b1;
                end else begin
                    hsub <= hsub + 1'b1;
                end
            end
            if (frame_end) begin
                row_base <= '0;
                vsub     <= '0;
            end else if (line_end && (vcnt < WIN_H)) begin
                if (vsub == SUB_LAST) begin
                    vsub     <= '0;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    vsub <= vsub + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            mode_q    <= PIX_RGB332;
        end else begin
            ram_addr  <= row_base + col;
            ram_rd_en <= in_win;
            if ((hcnt == '0) && (vcnt == '0)) begin
                mode_q <= pix_mode_e'(mode);
            end
        end
    end

    always_comb begin
        ctrl0        = CTRL_IDLE;
        ctrl0.hsync  = hsync_raw;
        ctrl0.vsync  = vsync_raw;
        ctrl0.active = active;
        ctrl0.in_win = in_win;
        ctrl0.fstart = (hcnt == '0) && (vcnt == '0);
        ctrl0.x      = hcnt[9:0];
        ctrl0.y      = vcnt[9:0];
    end

    // Control rides DL stages so it meets the RAM data at the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DL; i++) begin
                pipe[i] <= CTRL_IDLE;
            end
        end else begin
            pipe[0] <= ctrl0;
            for (int unsigned i = 1; i < DL; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign last = pipe[DL-1];

    always_comb begin
        pix = '0;
        if (last.active) begin
            if (!last.in_win) begin
                pix = BORDER;
            end else if (mode_q == PIX_GREY) begin
                pix = {3{ram_data}};
            end else begin
                pix = rgb332_expand(ram_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_b     <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            hsync       <= last.hsync;
            vsync       <= last.vsync;
            blank_b     <= last.active;
            {r, g, b}   <= pix;
            frame_start <= last.fstart;
            x           <= last.x;
            y           <= last.y;
        end
    end

    assign sync_b = 1'b1;

endmodule

// File: tb/tb_vga_display_engine.sv
// Scoreboard bench: two engines (RAM latency 1 and 3) on a reduced raster, checked
// against a time-stamped per-pixel reference model.
module tb_vga_display_engine;

    localparam int HA = 40, HFP = 4, HS = 6, HBP = 4;
    localparam int VA = 24, VFP = 2, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FBW = 8, FBH = 5, SC = 4;
    localparam logic [23:0] BRD = 24'h3C5A96;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       sync_b;
        logic       blank_b;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } out_t;

    typedef struct {
        int   due;
        out_t vec;
    } exp_t;

    localparam out_t IDLE = '{hsync: 1'b1, vsync: 1'b1, sync_b: 1'b1, blank_b: 1'b0,
                              r: 8'd0, g: 8'd0, b: 8'd0, fs: 1'b0, x: 10'd0, y: 10'd0};

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [7:0] mem [64];
    int         total = 0;
    int         bad = 0;
    int         first_fs [2] = '{-1, -1};

    always #5 clk = ~clk;

    function automatic logic [7:0] expand3(input int v);
        return 8'((v << 5) | (v << 2) | (v >> 1));
    endfunction

    function automatic out_t model_px(input int h, input int v, input int m);
        out_t o;
        int   d;
        logic act, win;
        act       = (h < HA) && (v < VA);
        win       = act && (h < FBW * SC) && (v < FBH * SC);
        o         = IDLE;
        o.hsync   = !((h >= HA + HFP) && (h < HA + HFP + HS));
        o.vsync   = !((v >= VA + VFP) && (v < VA + VFP + VS));
        o.blank_b = act;
        o.fs      = (h == 0) && (v == 0);
        o.x       = 10'(h);
        o.y       = 10'(v);
        if (act && !win) begin
            {o.r, o.g, o.b} = BRD;
        end else if (win) begin
            d = int'(mem[(v / SC) * FBW + h / SC]);
            if (m != 0) begin
                {o.r, o.g, o.b} = {3{8'(d)}};
            end else begin
                o.r = expand3(d >> 5);
                o.g = expand3((d >> 2) & 7);
                o.b = 8'((d & 3) * 85);
            end
        end
        return o;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        localparam int D = LAT + 2;

        logic [5:0] ram_addr;
        logic       ram_rd_en, hsync, vsync, sync_b, blank_b, frame_start;
        logic [7:0] ram_data, r, g, b;
        logic [9:0] x, y;
        logic [7:0] rq [LAT];

        vga_display_engine #(
            .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
            .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
            .FB_W (FBW), .FB_H (FBH), .SCALE (SC), .ADDR_W (6),
            .RAM_LAT (LAT), .BORDER (BRD)
        ) dut (
            .clk (clk), .rst (rst), .mode (mode), .ram_data (ram_data),
            .ram_addr (ram_addr), .ram_rd_en (ram_rd_en), .hsync (hsync),
            .vsync (vsync), .sync_b (sync_b), .blank_b (blank_b),
            .r (r), .g (g), .b (b), .frame_start (frame_start), .x (x), .y (y)
        );

        always @(posedge clk) begin
            rq[0] <= ram_rd_en ? mem[ram_addr] : 8'($urandom);
            for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
        end
        assign ram_data = rq[LAT-1];

        int         cyc = 0;
        int         mh = 0, mv = 0, fm = 0;
        logic       started = 1'b0;
        logic       exp_rd = 1'b0;
        logic [5:0] exp_addr = '0;
        exp_t       q [$];

        // Reference: each stage-0 pixel is scheduled to appear D-1 edges after it is consumed.
        initial forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                mh = 0; mv = 0; fm = 0;
                started  = 1'b1;
                exp_rd   = 1'b0;
                exp_addr = '0;
            end else if (started) begin
                if (mh == 0 && mv == 0) fm = int'(mode);
                q.push_back('{due: cyc + D - 1, vec: model_px(mh, mv, fm)});
                exp_rd   = (mh < FBW * SC) && (mv < FBH * SC);
                exp_addr = 6'((mv / SC) * FBW + mh / SC);
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end
            end
        end

        initial forever begin
            out_t got, want;
            @(negedge clk);
            if (started) begin
                got  = {hsync, vsync, sync_b, blank_b, r, g, b, frame_start, x, y};
                want = IDLE;
                if (q.size() > 0 && q[0].due == cyc) want = q.pop_front().vec;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL pix lat=%0d cyc=%0d got=%h want=%h", LAT, cyc, got, want);
                end
                total++;
                if (ram_rd_en !== exp_rd) begin
                    bad++;
                    $display("FAIL rd_en lat=%0d cyc=%0d got=%b want=%b", LAT, cyc, ram_rd_en, exp_rd);
                end
                if (exp_rd) begin
                    total++;
                    if (ram_addr !== exp_addr) begin
                        bad++;
                        $display("FAIL addr lat=%0d cyc=%0d got=%0d want=%0d", LAT, cyc, ram_addr, exp_addr);
                    end
                end
                if (frame_start === 1'b1 && first_fs[gi] < 0) first_fs[gi] = cyc;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            #1;
            rst = (c == 2 * HT * VT + 12 * HT + 7);
            if (c == 800) mode = 1'b1;
            else if (c == HT * VT + 800) mode = 1'b0;
            else if ($urandom_range(0, 499) == 0) mode = ~mode;
        end
        @(negedge clk);
        total++;
        if (first_fs[1] - first_fs[0] != 2) begin
            bad++;
            $display("FAIL lat_shift got=%0d want=2", first_fs[1] - first_fs[0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
